// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the fetch/data memory arbiter:
//               default widths, starvation counter width and the encoding
//               of the read-response owner register.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Counter is wide enough for the full legal STARVE_MAX range (1..15).
    localparam int STARVE_W       = 4;

    // Identifies which requester the read data arriving next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // Owner to record for a grant issued this cycle. Writes return no data,
    // so a data-port write leaves nothing outstanding.
    function automatic owner_e grant_owner(input logic if_gnt,
                                           input logic dm_gnt,
                                           input logic dm_we);
        owner_e own;
        own = OWN_NONE;
        if (if_gnt) begin
            own = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            own = OWN_DM;
        end
        return own;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Grant selection for the two memory requesters. Data accesses
//               win ties, except when fetch has already been passed over
//               STARVE_MAX consecutive times, in which case fetch wins.
// Revision    : 1.0 - initial release
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   i_if_req    in   fetch request
//   i_dm_req    in   data request
//   o_if_gnt    out  fetch granted this cycle (forced low during reset)
//   o_dm_gnt    out  data granted this cycle (forced low during reset)
// ============================================================================
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_if_gnt,
    output logic o_dm_gnt
);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_if_wins;
    logic                w_if_gnt;
    logic                w_dm_gnt;

    // Fetch wins when it is alone, or when the data port has used up its
    // allowance of consecutive wins over a waiting fetch.
    assign w_if_wins = i_if_req && (!i_dm_req || (r_starve_cnt == C_STARVE_MAX));

    assign w_if_gnt  = !reset && w_if_wins;
    assign w_dm_gnt  = !reset && i_dm_req && !w_if_wins;

    assign o_if_gnt  = w_if_gnt;
    assign o_dm_gnt  = w_dm_gnt;

    // Counts data grants that bypassed a waiting fetch. It restarts as soon
    // as fetch is served or stops asking, so only an unbroken run of
    // bypasses can force a fetch grant. The saturation term is defensive:
    // at the limit fetch always wins, so no data grant can push past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!i_if_req || w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_dm_gnt && (r_starve_cnt != C_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter shared by the instruction-fetch
//               and data-memory pipeline stages. Grants one access per cycle
//               to a synchronous-read memory and routes each read response,
//               which arrives one cycle after issue, back to its requester.
// Revision    : 1.0 - initial release
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   if_req     in   fetch read request, held with if_addr until if_gnt
//   if_addr    in   fetch byte address
//   if_gnt     out  fetch accepted this cycle
//   if_rvalid  out  if_rdata valid
//   if_rdata   out  fetch read data
//   dm_req     in   data request, held with dm_we/addr/wdata until dm_gnt
//   dm_we      in   1 = write, 0 = read
//   dm_addr    in   data byte address
//   dm_wdata   in   data write data
//   dm_gnt     out  data accepted this cycle
//   dm_rvalid  out  dm_rdata valid (reads only)
//   dm_rdata   out  data read data
//   mem_en     out  memory access this cycle
//   mem_we     out  memory write strobe
//   mem_addr   out  memory word address (byte address >> 2)
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid the cycle after a read issue
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   w_if_gnt;
    logic   w_dm_gnt;
    owner_e r_owner;
    logic   w_unused_addr_lsbs;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .i_if_req (if_req),
        .i_dm_req (dm_req),
        .o_if_gnt (w_if_gnt),
        .o_dm_gnt (w_dm_gnt)
    );

    assign if_gnt = w_if_gnt;
    assign dm_gnt = w_dm_gnt;

    // Memory is word addressed; byte lane bits are not used.
    assign w_unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

    // Grants are already held low during reset, so the memory strobes are too.
    assign mem_en    = w_if_gnt || w_dm_gnt;
    assign mem_we    = w_dm_gnt && dm_we;
    assign mem_addr  = w_dm_gnt ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
    // Only the data port writes, so its write data can go straight through.
    assign mem_wdata = dm_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= grant_owner(w_if_gnt, w_dm_gnt, dm_we);
        end
    end

    // The reset gate suppresses the response of a read that was issued in
    // the cycle just before reset was raised.
    assign if_rvalid = !reset && (r_owner == OWN_IF);
    assign dm_rvalid = !reset && (r_owner == OWN_DM);

    // Both ports see the memory output; rvalid says whose it is.
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a small memory
//               macro model, directed scenarios and a randomized run
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read, write-first memory macro.
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : mem[mem_addr[7:0]];
        end
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    // Stimulus-only helper used to set up memory contents.
    task automatic dm_write(input logic [31:0] a, input logic [31:0] d);
        if_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = a;
        dm_wdata = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if ({if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got=%b exp=000000", k,
                         {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid});
            end
            tick();
        end
        reset = 1'b0;
        idle();
        sample();
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got=%b exp=0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
        end
        tick();
    endtask

    task automatic test_fetch();
        dm_write(32'h4, 32'h2008_0005);
        if_req = 1'b1; if_addr = 32'h0000_0004;
        sample();
        checks++;
        if ({if_gnt, dm_gnt, mem_en, mem_we, dm_rvalid} !== 5'b10100) begin
            errors++;
            $display("FAIL fetch_grant got=%b exp=10100", {if_gnt, dm_gnt, mem_en, mem_we, dm_rvalid});
        end
        checks++;
        if (mem_addr !== 30'd1) begin
            errors++;
            $display("FAIL fetch_mem_addr got=%0d exp=1", mem_addr);
        end
        tick();
        idle();
        sample();
        checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'h2008_0005) begin
            errors++;
            $display("FAIL fetch_resp rv=%b data=%h exp rv=10 data=20080005", {if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
    endtask

    task automatic test_write_then_fetch();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
        sample();
        checks++;
        if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b0111 || mem_addr !== 30'd4 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_issue got=%b addr=%0d wd=%h exp=0111 addr=4 wd=deadbeef",
                     {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick();
        idle();
        if_req = 1'b1; if_addr = 32'h10;
        sample();
        checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b00 || if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wr_no_rvalid rv=%b if_gnt=%b exp rv=00 if_gnt=1", {if_rvalid, dm_rvalid}, if_gnt);
        end
        tick();
        idle();
        sample();
        checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_fetch rv=%b data=%h exp rv=10 data=deadbeef", {if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
    endtask

    task automatic test_alternating();
        dm_write(32'h0, 32'h1111_1111);
        dm_write(32'h8, 32'h2222_2222);
        if_req = 1'b1; if_addr = 32'h0;
        sample();
        checks++;
        if ({if_gnt, dm_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL alt_gnt0 got=%b exp=10", {if_gnt, dm_gnt});
        end
        tick();
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
        sample();
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0110 || if_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL alt_cyc1 got=%b data=%h exp=0110 data=11111111",
                     {if_gnt, dm_gnt, if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h4;
        sample();
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b1001 || dm_rdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL alt_cyc2 got=%b data=%h exp=1001 data=22222222",
                     {if_gnt, dm_gnt, if_rvalid, dm_rvalid}, dm_rdata);
        end
        tick();
        idle();
        sample();
        checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'h2008_0005) begin
            errors++;
            $display("FAIL alt_cyc3 rv=%b data=%h exp rv=10 data=20080005", {if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
    endtask

    task automatic test_starve();
        logic prev_if;
        prev_if = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
        for (int k = 0; k < 10; k++) begin
            logic exp_if;
            exp_if = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
            sample();
            checks++;
            if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
                errors++;
                $display("FAIL starve_seq cyc%0d got=%b exp=%b", k, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
            end
            if (k > 0) begin
                checks++;
                if ({if_rvalid, dm_rvalid} !== {prev_if, ~prev_if} ||
                    (prev_if ? if_rdata : dm_rdata) !== (prev_if ? 32'h1111_1111 : 32'h2222_2222)) begin
                    errors++;
                    $display("FAIL starve_resp cyc%0d rv=%b exp=%b", k, {if_rvalid, dm_rvalid}, {prev_if, ~prev_if});
                end
            end
            prev_if = exp_if;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_outstanding();
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++;
            if (dm_gnt !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_dm cyc%0d got=%b exp=1", k, dm_gnt);
            end
            tick();
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if ({if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL mid_reset cyc%0d got=%b exp=000000", k,
                         {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid});
            end
            tick();
        end
        reset = 1'b0;
        // A cleared starvation count gives the full STARVE_MAX data run again.
        for (int k = 0; k <= STARVE_MAX; k++) begin
            logic exp_if;
            exp_if = (k == STARVE_MAX);
            sample();
            checks++;
            if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
                errors++;
                $display("FAIL post_reset_seq cyc%0d got=%b exp=%b", k, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
            end
            if (k == 0) begin
                checks++;
                if ({if_rvalid, dm_rvalid} !== 2'b00) begin
                    errors++;
                    $display("FAIL post_reset_rvalid got=%b exp=00", {if_rvalid, dm_rvalid});
                end
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_dm_priority();
        if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
        for (int k = 0; k < 8; k++) begin
            sample();
            checks++;
            if ({if_gnt, dm_gnt} !== 2'b01) begin
                errors++;
                $display("FAIL dm_alone cyc%0d got=%b exp=01", k, {if_gnt, dm_gnt});
            end
            tick();
        end
        if_req = 1'b1; if_addr = 32'h4;
        for (int k = 0; k <= STARVE_MAX; k++) begin
            logic exp_if;
            exp_if = (k == STARVE_MAX);
            sample();
            checks++;
            if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
                errors++;
                $display("FAIL dm_then_if cyc%0d got=%b exp=%b", k, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
            end
            tick();
        end
        idle();
        tick();
    endtask

    // Transaction-level model: each requester holds one pending access until
    // it is served; the model picks the winner from the priority rules and
    // keeps its own copy of memory to predict read data.
    task automatic test_random();
        logic [31:0] ref_mem [0:15];
        logic        if_pend, dm_pend, dwe;
        logic [31:0] ia, da, dwd, exp_data;
        int          starve, exp_own;
        logic        g_if, g_dm;

        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            dm_write(32'(w) << 2, ref_mem[w]);
        end
        tick();
        if_pend = 1'b0; dm_pend = 1'b0; dwe = 1'b0;
        ia = '0; da = '0; dwd = '0; exp_data = '0;
        starve = 0; exp_own = 0;

        for (int c = 0; c < 400; c++) begin
            if (!if_pend && $urandom_range(0, 99) < 60) begin
                if_pend = 1'b1;
                ia      = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dm_pend && $urandom_range(0, 99) < 70) begin
                dm_pend = 1'b1;
                dwe     = ($urandom_range(0, 2) == 0);
                da      = 32'($urandom_range(0, 15)) << 2;
                dwd     = $urandom;
            end
            if_req = if_pend; if_addr = ia;
            dm_req = dm_pend; dm_we = dwe; dm_addr = da; dm_wdata = dwd;

            g_if = if_pend && (!dm_pend || starve == STARVE_MAX);
            g_dm = dm_pend && !g_if;

            sample();
            checks++;
            if ({if_gnt, dm_gnt, mem_en, mem_we} !== {g_if, g_dm, g_if | g_dm, g_dm & dwe}) begin
                errors++;
                $display("FAIL rnd_grant c%0d got=%b exp=%b", c,
                         {if_gnt, dm_gnt, mem_en, mem_we}, {g_if, g_dm, g_if | g_dm, g_dm & dwe});
            end
            if (g_if || g_dm) begin
                checks++;
                if (mem_addr !== (g_dm ? da[31:2] : ia[31:2]) || (g_dm && dwe && mem_wdata !== dwd)) begin
                    errors++;
                    $display("FAIL rnd_mem c%0d addr=%0d wd=%h exp addr=%0d", c, mem_addr, mem_wdata,
                             g_dm ? da[31:2] : ia[31:2]);
                end
            end
            checks++;
            if ({if_rvalid, dm_rvalid} !== {exp_own == 1, exp_own == 2} ||
                (exp_own == 1 && if_rdata !== exp_data) ||
                (exp_own == 2 && dm_rdata !== exp_data)) begin
                errors++;
                $display("FAIL rnd_resp c%0d rv=%b ifd=%h dmd=%h exp own=%0d data=%h", c,
                         {if_rvalid, dm_rvalid}, if_rdata, dm_rdata, exp_own, exp_data);
            end

            exp_own = 0;
            if (g_if) begin
                exp_own  = 1;
                exp_data = ref_mem[ia[5:2]];
                if_pend  = 1'b0;
            end else if (g_dm) begin
                if (dwe) begin
                    ref_mem[da[5:2]] = dwd;
                end else begin
                    exp_own  = 2;
                    exp_data = ref_mem[da[5:2]];
                end
                dm_pend = 1'b0;
            end
            if (g_if || !if_req) starve = 0;
            else if (g_dm)       starve = starve + 1;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        tick();
        test_reset();
        test_fetch();
        test_write_then_fetch();
        test_alternating();
        test_starve();
        test_reset_outstanding();
        test_dm_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
